ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the number of entries in the fetched-instruction buffer (legal range 2..8).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port redirect_in, input, 1, the branch/jump taken strobe.
REQ-006 SHALL have port redirect_addr_in, input, ARCH, the new fetch target.
REQ-007 SHALL have port imem_req_out, output, 1, the instruction memory read request.
REQ-008 SHALL have port imem_addr_out, output, ARCH, the byte address of the request.
REQ-009 SHALL have port imem_rdata_in, input, ARCH, the read data, valid exactly one cycle after the request.
REQ-010 SHALL have port instr_out, output, ARCH, the instruction word presented to decode.
REQ-011 SHALL have port instr_pc_out, output, ARCH, the PC of instr_out.
REQ-012 SHALL have port instr_valid_out, output, 1, which is high when instr_out/instr_pc_out are valid.
REQ-013 SHALL have port instr_ready_in, input, 1, the decode-stage accept signal.

Function
REQ-014 SHALL hold a fetch_pc register, issuing imem_req_out=1 with imem_addr_out=fetch_pc when (fifo_count + inflight) < FIFO_DEPTH and redirect_in=0.
REQ-015 SHALL advance fetch_pc by 4 on each issued request; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-016 SHALL set the inflight flag on issue and, in the next cycle, push {pc, imem_rdata_in} into the FIFO unless squashed.
REQ-017 SHALL drive instr_valid_out = FIFO non-empty, and instr_out/instr_pc_out = head entry; the outputs are held stable while valid is high and ready is low.
REQ-018 SHALL pop the head when instr_valid_out && instr_ready_in; push and pop in the same cycle are both honoured, including at full.
REQ-019 SHALL, on redirect_in=1: flush all FIFO entries, squash any inflight response, load fetch_pc <= redirect_addr_in, and suppress the request in that cycle.
REQ-020 SHALL give redirect priority over a simultaneous pop and push; a handshake in the redirect cycle is discarded and not counted as consumed.
REQ-021 SHALL have latency: a request in cycle N gives instr_valid_out in cycle N+2; a redirect in cycle N gives a request to the target in N+1 and valid in N+3.
REQ-022 SHALL sustain one instruction per cycle when instr_ready_in is held high.
REQ-023 SHALL use back-to-back redirects so that only the last redirect_addr_in takes effect.

Reset
REQ-024 SHALL, while rst_n=0: fetch_pc=RESET_PC, FIFO empty, inflight=0, imem_req_out=0, instr_valid_out=0, instr_out=0, instr_pc_out=0.
REQ-025 SHALL, when rst_n is asserted mid-operation, discard all pending entries and any inflight response immediately; the first request after release is to RESET_PC.

Configuration
REQ-026 SHALL, with FRISCV_IFETCH_ALIGN_CHK_EN defined, add output misalign_err_out (1 bit): it sets sticky when a redirect has redirect_addr_in[1:0]!=0 and clears only on reset; the redirect is still taken with bits [1:0] forced to 0.
REQ-027 SHALL, without FRISCV_IFETCH_ALIGN_CHK_EN, omit the port and silently force redirect_addr_in[1:0] to 0.

Structure
REQ-028 SHALL place typedef fetch_entry_t {pc, instr} and the constant INSTR_BYTES=4 in friscv_pkg, and reuse ARCH from friscv_pkg.
REQ-029 SHALL instantiate the FIFO as sub-module fetch_fifo (parameterised depth and entry type, with flush input).

Verification
REQ-030 SHALL cover: reset release with RESET_PC=0 and ready=1 -> requests to 0x0,0x4,0x8...; instr_valid_out first high 2 cycles after the first request; one instruction per cycle.
REQ-031 SHALL cover: ready=0 for 6 cycles -> FIFO fills to FIFO_DEPTH, imem_req_out drops to 0, and instr_out/instr_pc_out stay stable at PC 0x0.
REQ-032 SHALL cover: redirect to 0x100 while the FIFO is full and a request is inflight -> no entry with PC<0x100 reaches the output; next valid PC is 0x100 at N+3.
REQ-033 SHALL cover: redirect in the same cycle as a valid/ready handshake -> the popped entry is discarded and the next output PC equals the redirect target.
REQ-034 SHALL cover: fetch_pc=0xFFFF_FFF8 -> the request sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-035 SHALL cover, with FRISCV_IFETCH_ALIGN_CHK_EN: redirect to 0x102 -> misalign_err_out=1 from the next cycle, fetch resumes at 0x100, and the error stays high until rst_n=0.

Source files
------------

// File: rtl/friscv_pkg.sv
// Shared types and constants for the friscv fetch front end.
package friscv_pkg;

    localparam int ARCH        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [ARCH-1:0] pc;
        logic [ARCH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetched instructions; flush empties it in one cycle and
// wins over a simultaneous push or pop. A push into a full FIFO is accepted when a pop happens too.
module fetch_fifo
    import friscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush_i,
    input  logic                           push_i,
    input  entry_t                         data_i,
    input  logic                           pop_i,
    output entry_t                         data_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH + 1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty_o  = (count_q == '0);
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: sequential PC generation, one-cycle imem, buffered output with redirect.
// Define FRISCV_IFETCH_ALIGN_CHK_EN to add the sticky misalign_err_out port.
module ifetch_unit
    import friscv_pkg::*;
#(
    parameter logic [ARCH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_in,
    input  logic [ARCH-1:0] redirect_addr_in,
    output logic            imem_req_out,
    output logic [ARCH-1:0] imem_addr_out,
    input  logic [ARCH-1:0] imem_rdata_in,
    output logic [ARCH-1:0] instr_out,
    output logic [ARCH-1:0] instr_pc_out,
    output logic            instr_valid_out,
    input  logic            instr_ready_in
`ifdef FRISCV_IFETCH_ALIGN_CHK_EN
    ,
    output logic            misalign_err_out
`endif
);

    localparam int unsigned     CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [ARCH-1:0] ALIGN_MASK = ~ARCH'(INSTR_BYTES - 1);

    logic [ARCH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ARCH-1:0]  inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic             run_q;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    logic             fifo_empty;
    logic             pop;
    logic             issue;
    logic [ARCH-1:0]  redirect_tgt;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    // A slot freed by this cycle's pop counts as free, so ready=1 sustains one instr per cycle.
    always_comb begin
        pop          = !fifo_empty && instr_ready_in;
        occupancy    = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
        issue        = run_q && !redirect_in && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
        redirect_tgt = redirect_addr_in & ALIGN_MASK;

        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (redirect_in) begin
            fetch_pc_d = redirect_tgt;
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + ARCH'(INSTR_BYTES);
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            run_q         <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            run_q         <= 1'b1;
        end
    end

    assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata_in};

    // Flush on redirect also drops the response arriving this cycle.
    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_in),
        .push_i  (inflight_q),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign imem_req_out    = issue;
    assign imem_addr_out   = fetch_pc_q;
    assign instr_valid_out = !fifo_empty;
    assign instr_out       = fifo_empty ? '0 : head_entry.instr;
    assign instr_pc_out    = fifo_empty ? '0 : head_entry.pc;

`ifdef FRISCV_IFETCH_ALIGN_CHK_EN
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = misalign_q | (redirect_in & (|redirect_addr_in[1:0]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end

    assign misalign_err_out = misalign_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: startup, stall, redirects, wrap and (optionally) misalign.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_in;
    logic [31:0] redirect_addr_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic [31:0] imem_rdata_in = '0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_valid_out;
    logic        instr_ready_in;
`ifdef FRISCV_IFETCH_ALIGN_CHK_EN
    logic        misalign_err_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ifetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_in      (redirect_in),
        .redirect_addr_in (redirect_addr_in),
        .imem_req_out     (imem_req_out),
        .imem_addr_out    (imem_addr_out),
        .imem_rdata_in    (imem_rdata_in),
        .instr_out        (instr_out),
        .instr_pc_out     (instr_pc_out),
        .instr_valid_out  (instr_valid_out),
        .instr_ready_in   (instr_ready_in)
`ifdef FRISCV_IFETCH_ALIGN_CHK_EN
        ,
        .misalign_err_out (misalign_err_out)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // One-cycle-latency instruction memory.
    always @(posedge clk) begin
        if (imem_req_out) imem_rdata_in <= instr_of(imem_addr_out);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic exp_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"}, 32'(imem_req_out), 32'(req));
        if (req) chk({tag, ".addr"}, imem_addr_out, addr);
    endtask

    task automatic exp_out(input string tag, input logic valid, input logic [31:0] pc);
        chk({tag, ".valid"}, 32'(instr_valid_out), 32'(valid));
        chk({tag, ".pc"}, instr_pc_out, valid ? pc : 32'h0);
        chk({tag, ".instr"}, instr_out, valid ? instr_of(pc) : 32'h0);
    endtask

    task automatic redirect(input logic en, input logic [31:0] addr);
        redirect_in      = en;
        redirect_addr_in = addr;
        #1;
    endtask

    initial begin
        rst_n            = 1'b0;
        redirect_in      = 1'b0;
        redirect_addr_in = '0;
        instr_ready_in   = 1'b1;
        repeat (3) step();
        exp_req("rst", 1'b0, 32'h0);
        exp_out("rst", 1'b0, 32'h0);
`ifdef FRISCV_IFETCH_ALIGN_CHK_EN
        chk("rst.misalign", 32'(misalign_err_out), 32'h0);
`endif
        rst_n = 1'b1;

        // Startup with ready held high: one instruction per cycle after 2-cycle latency.
        step(); exp_req("c0", 1'b1, 32'h0);  exp_out("c0", 1'b0, 32'h0);
        step(); exp_req("c1", 1'b1, 32'h4);  exp_out("c1", 1'b0, 32'h0);
        step(); exp_req("c2", 1'b1, 32'h8);  exp_out("c2", 1'b1, 32'h0);
        step(); exp_req("c3", 1'b1, 32'hC);  exp_out("c3", 1'b1, 32'h4);
        step(); exp_req("c4", 1'b1, 32'h10); exp_out("c4", 1'b1, 32'h8);

        // Reset mid-operation clears everything at once.
        step(); rst_n = 1'b0; #1;
        exp_req("mrst", 1'b0, 32'h0);
        exp_out("mrst", 1'b0, 32'h0);
        instr_ready_in = 1'b0;
        step(); rst_n = 1'b1;

        // Stall: FIFO fills, requests stop, head holds PC 0.
        step(); exp_req("d0", 1'b1, 32'h0); exp_out("d0", 1'b0, 32'h0);
        step(); exp_req("d1", 1'b1, 32'h4); exp_out("d1", 1'b0, 32'h0);
        for (int i = 2; i <= 6; i++) begin
            step();
            exp_req($sformatf("d%0d", i), 1'b0, 32'h0);
            exp_out($sformatf("d%0d", i), 1'b1, 32'h0);
        end

        // Redirect while full: nothing below 0x100 may appear afterwards.
        step(); redirect(1'b1, 32'h100);
        exp_req("d7", 1'b0, 32'h0); exp_out("d7", 1'b1, 32'h0);
        step(); redirect(1'b0, 32'h0); instr_ready_in = 1'b1; #1;
        exp_req("d8", 1'b1, 32'h100); exp_out("d8", 1'b0, 32'h0);
        step(); exp_req("d9", 1'b1, 32'h104); exp_out("d9", 1'b0, 32'h0);
        step(); exp_req("d10", 1'b1, 32'h108); exp_out("d10", 1'b1, 32'h100);
        step(); exp_out("d11", 1'b1, 32'h104);

        // Redirect during a handshake, then back-to-back redirect: only 0x200 counts.
        step(); redirect(1'b1, 32'h300);
        exp_req("d12", 1'b0, 32'h0); exp_out("d12", 1'b1, 32'h108);
        step(); redirect(1'b1, 32'h200);
        exp_req("d13", 1'b0, 32'h0); exp_out("d13", 1'b0, 32'h0);
        step(); redirect(1'b0, 32'h0);
        exp_req("d14", 1'b1, 32'h200); exp_out("d14", 1'b0, 32'h0);
        step(); exp_req("d15", 1'b1, 32'h204); exp_out("d15", 1'b0, 32'h0);
        step(); exp_out("d16", 1'b1, 32'h200);
        step(); exp_out("d17", 1'b1, 32'h204);
`ifdef FRISCV_IFETCH_ALIGN_CHK_EN
        chk("d17.misalign", 32'(misalign_err_out), 32'h0);
`endif

        // Address wrap at the top of the space.
        step(); redirect(1'b1, 32'hFFFF_FFF8);
        exp_out("f0", 1'b1, 32'h208);
        step(); redirect(1'b0, 32'h0);
        exp_req("f1", 1'b1, 32'hFFFF_FFF8);
        step(); exp_req("f2", 1'b1, 32'hFFFF_FFFC);
        step(); exp_req("f3", 1'b1, 32'h0); exp_out("f3", 1'b1, 32'hFFFF_FFF8);
        step(); exp_req("f4", 1'b1, 32'h4); exp_out("f4", 1'b1, 32'hFFFF_FFFC);
        step(); exp_out("f5", 1'b1, 32'h0);

        // Misaligned redirect target: low bits dropped, flag sticky when enabled.
        step(); redirect(1'b1, 32'h102);
        exp_req("g0", 1'b0, 32'h0);
`ifdef FRISCV_IFETCH_ALIGN_CHK_EN
        chk("g0.misalign", 32'(misalign_err_out), 32'h0);
`endif
        step(); redirect(1'b0, 32'h0);
        exp_req("g1", 1'b1, 32'h100);
`ifdef FRISCV_IFETCH_ALIGN_CHK_EN
        chk("g1.misalign", 32'(misalign_err_out), 32'h1);
`endif
        step(); exp_req("g2", 1'b1, 32'h104);
        step(); exp_out("g3", 1'b1, 32'h100);
        step(); exp_out("g4", 1'b1, 32'h104);
`ifdef FRISCV_IFETCH_ALIGN_CHK_EN
        chk("g4.misalign", 32'(misalign_err_out), 32'h1);
`endif
        step(); rst_n = 1'b0; #1;
        exp_out("end_rst", 1'b0, 32'h0);
`ifdef FRISCV_IFETCH_ALIGN_CHK_EN
        chk("end_rst.misalign", 32'(misalign_err_out), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
